multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter MEM_WAIT_MAX, default 15, meaning the maximum mem_ready wait cycles before mem_err pulses.
REQ-002 SHALL have port clk, input, 1, the single clock, rising-edge.
REQ-003 SHALL have port rst, input, 1, the reset, asynchronous and active-low.
REQ-004 SHALL have port instr, input, 16, the current instruction from memory; [15:12] opcode, [1:0] cz.
REQ-005 SHALL have port mem_ready, input, 1, memory access complete this cycle.
REQ-006 SHALL have ports c_flag and z_flag, input, 1 each, the architectural flag register values.
REQ-007 SHALL have port alu_z, input, 1, the ALU zero result, used for BEQ.
REQ-008 SHALL have ports ir_we, pc_we, rf_we, mem_rd, mem_wr, flag_c_we and flag_z_we, output, 1 each, write and access strobes.
REQ-009 SHALL have port pc_src, output, 2, selecting the next PC: 00 PC+1, 01 PC+imm, 10 register.
REQ-010 SHALL have port alu_opcode, output, 4, and port alu_cz, output, 2, both driven to the ALU.
REQ-011 SHALL have port alu_b_sel, output, 2, selecting ALU operand B: 00 register B, 01 imm6 sign-extended, 10 constant 1.
REQ-012 SHALL have port rf_wd_sel, output, 2, selecting register write data: 00 ALU result, 01 memory data, 10 PC, 11 imm9<<7.
REQ-013 SHALL have port mem_err, output, 1, a one-cycle pulse on memory timeout.
REQ-014 SHALL have port state_o, output, 3, the current state for debug.

Function
REQ-015 SHALL implement states FETCH, DECODE, EXEC, MEM and WB, with one-cycle DECODE.
REQ-016 FETCH SHALL assert mem_rd; when mem_ready=1 it SHALL pulse ir_we and pc_we (pc_src=00), latch instr internally and go to DECODE; otherwise it SHALL stay in FETCH.
REQ-017 DECODE SHALL go to EXEC for every opcode.
REQ-018 Opcode 0000 (ADI) SHALL use EXEC with alu_b_sel=01, then WB with rf_we, flag_c_we and flag_z_we set; it SHALL take 4 cycles with zero-wait memory.
REQ-019 Opcode 0001 (ADD) SHALL use EXEC with alu_opcode=0001 and alu_cz=cz, then WB; for cz=01 with z_flag=0, or cz=10 with c_flag=0, WB SHALL assert no rf_we and no flag writes.
REQ-020 Opcode 0010 (NDU) SHALL write only rf_we and flag_z_we when its condition holds; cz=11 SHALL behave as a NOP (no writes) and return to FETCH after EXEC.
REQ-021 Opcode 0011 (LHI) SHALL assert rf_we with rf_wd_sel=11 in EXEC and then go to FETCH.
REQ-022 Opcode 0100 (LW) SHALL compute the address in EXEC, go to MEM (mem_rd held until mem_ready), then WB with rf_wd_sel=01, rf_we and flag_z_we set.
REQ-023 Opcode 0101 (SW) SHALL compute the address in EXEC, then go to MEM with mem_wr held until mem_ready, then go to FETCH.
REQ-024 Opcode 1000 (BEQ) SHALL drive alu_opcode=1000 in EXEC; if alu_z=1 it SHALL pulse pc_we with pc_src=01; it SHALL then go to FETCH.
REQ-025 Opcode 1001 (JAL) SHALL, in EXEC, pulse rf_we with rf_wd_sel=10 and pc_we with pc_src=01, then go to FETCH.
REQ-026 Opcode 1010 (JLR) SHALL do the same as JAL with pc_src=10.
REQ-027 Any other opcode SHALL be a NOP: no writes, and a return to FETCH after EXEC.
REQ-028 Conditions SHALL be evaluated with c_flag and z_flag sampled in EXEC and held in a register until WB.
REQ-029 A wait in FETCH or MEM that exceeds MEM_WAIT_MAX cycles SHALL pulse mem_err, drop the access and go to FETCH with PC unchanged.
REQ-030 All strobes SHALL be Moore outputs decoded from the state and the latched instruction, and all outputs SHALL be glitch-free on the clock edge.
REQ-031 pc_we and rf_we SHALL each assert for at most one cycle per instruction.

Reset
REQ-032 When rst=0 the block SHALL asynchronously enter FETCH, clear the latched instruction to 0000, clear the wait counter, and drive all strobes and mem_err to 0.
REQ-033 A reset in any state SHALL abort the instruction with no further writes.
REQ-034 The first mem_rd after reset SHALL occur on the first clock after rst deasserts.

Structure
REQ-035 A shared package SHALL hold the opcode constants, the state encoding, and the pc_src, alu_b_sel and rf_wd_sel encodings.
REQ-036 A sub-module cond_eval SHALL map (opcode, cz, c_flag, z_flag) to an execute-enable bit.

Verification
REQ-037 The bench SHALL run ADI (instr 0x0000 class) with mem_ready always 1 and SHALL see FETCH, DECODE, EXEC, WB in 4 cycles, with rf_we, flag_c_we and flag_z_we high in WB only.
REQ-038 The bench SHALL run ADZ (opcode 0001, cz=01) with z_flag=0 and SHALL see no rf_we and no flag writes; with z_flag=1 it SHALL see rf_we=1.
REQ-039 The bench SHALL run LW with mem_ready low for 3 cycles in MEM and SHALL see mem_rd held for 4 cycles, then WB with rf_wd_sel=01.
REQ-040 The bench SHALL run BEQ with alu_z=1 and SHALL see pc_we=1 with pc_src=01 in EXEC; with alu_z=0 it SHALL see pc_we=0 in EXEC.
REQ-041 The bench SHALL hold mem_ready=0 in FETCH for 16 cycles and SHALL see mem_err pulse once and FETCH re-enter.
REQ-042 The bench SHALL assert rst low during MEM of an SW and SHALL see mem_wr drop immediately, no rf_we, and state_o equal to the FETCH encoding.

Source files
------------

// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multicycle control unit.
// Holds the FSM state encoding, the opcode constants, and the select
// encodings for pc_src, alu_b_sel and rf_wd_sel, plus the bundle of
// strobes the output decoder produces each cycle.
package multicycle_control_unit_pkg;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;

    localparam logic [3:0] OP_ADI = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_NDU = 4'b0010;
    localparam logic [3:0] OP_LHI = 4'b0011;
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_SW  = 4'b0101;
    localparam logic [3:0] OP_BEQ = 4'b1000;
    localparam logic [3:0] OP_JAL = 4'b1001;
    localparam logic [3:0] OP_JLR = 4'b1010;

    localparam logic [1:0] PC_SRC_INC = 2'b00;
    localparam logic [1:0] PC_SRC_IMM = 2'b01;
    localparam logic [1:0] PC_SRC_REG = 2'b10;

    localparam logic [1:0] B_SEL_REG  = 2'b00;
    localparam logic [1:0] B_SEL_IMM6 = 2'b01;
    localparam logic [1:0] B_SEL_ONE  = 2'b10;

    localparam logic [1:0] WD_ALU  = 2'b00;
    localparam logic [1:0] WD_MEM  = 2'b01;
    localparam logic [1:0] WD_PC   = 2'b10;
    localparam logic [1:0] WD_IMM9 = 2'b11;

    typedef struct packed {
        logic       ir_we;
        logic       pc_we;
        logic       rf_we;
        logic       mem_rd;
        logic       mem_wr;
        logic       flag_c_we;
        logic       flag_z_we;
        logic [1:0] pc_src;
        logic [1:0] alu_b_sel;
        logic [1:0] rf_wd_sel;
    } ctrl_t;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/multicycle_control_unit_cond_eval.sv
// cond_eval: decides whether the latched instruction may commit its writes.
// ADD and NDU are conditional on cz: 00 always, 01 when Z is set,
// 10 when C is set. cz=11 is unconditional for ADD and a NOP for NDU.
// Every other opcode always executes.
// Ports:
//   i_opcode, i_cz      latched instruction fields
//   i_c_flag, i_z_flag  architectural flags
//   o_exec_en           1 = instruction may perform its writes
module cond_eval
    import multicycle_control_unit_pkg::*;
(
    input  logic [3:0] i_opcode,
    input  logic [1:0] i_cz,
    input  logic       i_c_flag,
    input  logic       i_z_flag,
    output logic       o_exec_en
);

    always_comb begin
        o_exec_en = 1'b1;
        if ((i_opcode == OP_ADD) || (i_opcode == OP_NDU)) begin
            case (i_cz)
                2'b01:   o_exec_en = i_z_flag;
                2'b10:   o_exec_en = i_c_flag;
                2'b11:   o_exec_en = (i_opcode == OP_ADD);
                default: o_exec_en = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB sequencer for a 16-bit
// multicycle datapath. Strobes are decoded from the state register, the
// latched opcode/cz and the condition bit registered in EXEC; only the
// memory handshake (mem_ready in FETCH) and the BEQ compare (alu_z) qualify
// them combinationally.
// Ports:
//   clk, rst (async, active-low)
//   instr[15:0]       instruction word from memory ([15:12] opcode, [1:0] cz)
//   mem_ready         memory access completes this cycle
//   c_flag, z_flag    flag register values
//   alu_z             ALU zero result (BEQ)
//   ir_we, pc_we, rf_we, mem_rd, mem_wr, flag_c_we, flag_z_we   strobes
//   pc_src, alu_opcode, alu_cz, alu_b_sel, rf_wd_sel             selects
//   mem_err           one-cycle pulse on memory wait timeout
//   state_o           current state (debug)
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        mem_ready,
    input  logic        c_flag,
    input  logic        z_flag,
    input  logic        alu_z,
    output logic        ir_we,
    output logic        pc_we,
    output logic        rf_we,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        flag_c_we,
    output logic        flag_z_we,
    output logic [1:0]  pc_src,
    output logic [3:0]  alu_opcode,
    output logic [1:0]  alu_cz,
    output logic [1:0]  alu_b_sel,
    output logic [1:0]  rf_wd_sel,
    output logic        mem_err,
    output logic [2:0]  state_o
);

    localparam int WAIT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);

    state_t            r_state;
    logic [3:0]        r_opcode;
    logic [1:0]        r_cz;
    logic              r_exec_en;
    logic              r_run;
    logic [WAIT_W-1:0] r_wait;
    logic              r_mem_err;

    state_t            w_next;
    logic              w_exec_en;
    logic              w_in_access;
    logic              w_wait_over;
    ctrl_t             w_ctrl;
    logic              w_unused_instr;

    // Operand/immediate fields are consumed by the datapath, not here.
    assign w_unused_instr = ^instr[11:2];

    cond_eval u_cond_eval (
        .i_opcode (r_opcode),
        .i_cz     (r_cz),
        .i_c_flag (c_flag),
        .i_z_flag (z_flag),
        .o_exec_en(w_exec_en)
    );

    assign w_in_access = (r_state == ST_FETCH) || (r_state == ST_MEM);
    // Fires on the first waiting cycle beyond MEM_WAIT_MAX.
    assign w_wait_over = w_in_access && !mem_ready &&
                         (r_wait == WAIT_W'(MEM_WAIT_MAX));

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH:  w_next = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: w_next = ST_EXEC;
            ST_EXEC: begin
                if (is_mem_op(r_opcode))
                    w_next = ST_MEM;
                else if ((r_opcode == OP_ADI) || (r_opcode == OP_ADD))
                    w_next = ST_WB;
                else if (r_opcode == OP_NDU)
                    w_next = (r_cz == 2'b11) ? ST_FETCH : ST_WB;
                else
                    w_next = ST_FETCH;
            end
            ST_MEM: begin
                if (mem_ready)
                    w_next = (r_opcode == OP_LW) ? ST_WB : ST_FETCH;
                else if (w_wait_over)
                    w_next = ST_FETCH;
            end
            ST_WB:     w_next = ST_FETCH;
            default:   w_next = ST_FETCH;
        endcase
    end

    // r_run holds the FSM (and every strobe) idle for the first clock
    // after reset so nothing is driven until the block is clocked.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_FETCH;
            r_opcode  <= OP_ADI;
            r_cz      <= 2'b00;
            r_exec_en <= 1'b0;
            r_run     <= 1'b0;
            r_wait    <= '0;
            r_mem_err <= 1'b0;
        end else if (!r_run) begin
            r_run     <= 1'b1;
            r_mem_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_mem_err <= w_wait_over;
            if (w_in_access && !mem_ready && !w_wait_over)
                r_wait <= r_wait + WAIT_W'(1);
            else
                r_wait <= '0;
            if ((r_state == ST_FETCH) && mem_ready) begin
                r_opcode <= instr[15:12];
                r_cz     <= instr[1:0];
            end
            // Flags are sampled here so WB decides on EXEC-time values.
            if (r_state == ST_EXEC)
                r_exec_en <= w_exec_en;
        end
    end

    always_comb begin
        w_ctrl           = '0;
        w_ctrl.pc_src    = PC_SRC_INC;
        w_ctrl.alu_b_sel = B_SEL_REG;
        w_ctrl.rf_wd_sel = WD_ALU;
        if (r_run) begin
            case (r_state)
                ST_FETCH: begin
                    w_ctrl.mem_rd = 1'b1;
                    w_ctrl.ir_we  = mem_ready;
                    w_ctrl.pc_we  = mem_ready;
                end
                ST_EXEC: begin
                    case (r_opcode)
                        OP_ADI, OP_LW, OP_SW: w_ctrl.alu_b_sel = B_SEL_IMM6;
                        OP_LHI: begin
                            w_ctrl.rf_we     = 1'b1;
                            w_ctrl.rf_wd_sel = WD_IMM9;
                        end
                        OP_BEQ: begin
                            w_ctrl.pc_we  = alu_z;
                            w_ctrl.pc_src = PC_SRC_IMM;
                        end
                        OP_JAL, OP_JLR: begin
                            w_ctrl.rf_we     = 1'b1;
                            w_ctrl.rf_wd_sel = WD_PC;
                            w_ctrl.pc_we     = 1'b1;
                            w_ctrl.pc_src    = (r_opcode == OP_JAL) ? PC_SRC_IMM : PC_SRC_REG;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    // Keep the address operand stable while memory waits.
                    w_ctrl.alu_b_sel = B_SEL_IMM6;
                    w_ctrl.mem_rd    = (r_opcode == OP_LW);
                    w_ctrl.mem_wr    = (r_opcode == OP_SW);
                end
                ST_WB: begin
                    case (r_opcode)
                        OP_ADI, OP_ADD: begin
                            w_ctrl.alu_b_sel = (r_opcode == OP_ADI) ? B_SEL_IMM6 : B_SEL_REG;
                            w_ctrl.rf_we     = r_exec_en;
                            w_ctrl.flag_c_we = r_exec_en;
                            w_ctrl.flag_z_we = r_exec_en;
                        end
                        OP_NDU: begin
                            w_ctrl.rf_we     = r_exec_en;
                            w_ctrl.flag_z_we = r_exec_en;
                        end
                        OP_LW: begin
                            w_ctrl.rf_we     = r_exec_en;
                            w_ctrl.flag_z_we = r_exec_en;
                            w_ctrl.rf_wd_sel = WD_MEM;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign ir_we      = w_ctrl.ir_we;
    assign pc_we      = w_ctrl.pc_we;
    assign rf_we      = w_ctrl.rf_we;
    assign mem_rd     = w_ctrl.mem_rd;
    assign mem_wr     = w_ctrl.mem_wr;
    assign flag_c_we  = w_ctrl.flag_c_we;
    assign flag_z_we  = w_ctrl.flag_z_we;
    assign pc_src     = w_ctrl.pc_src;
    assign alu_b_sel  = w_ctrl.alu_b_sel;
    assign rf_wd_sel  = w_ctrl.rf_wd_sel;
    assign alu_opcode = r_opcode;
    assign alu_cz     = r_cz;
    assign mem_err    = r_mem_err;
    assign state_o    = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed scenarios followed by random
// instructions, each checked against an instruction-level expectation of
// cycle count, write counts, selects and memory strobe durations.
module tb_multicycle_control_unit;
    import multicycle_control_unit_pkg::*;

    localparam int MEM_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic        mem_ready, c_flag, z_flag, alu_z;
    logic        ir_we, pc_we, rf_we, mem_rd, mem_wr, flag_c_we, flag_z_we;
    logic [1:0]  pc_src, alu_cz, alu_b_sel, rf_wd_sel;
    logic [3:0]  alu_opcode;
    logic        mem_err;
    logic [2:0]  state_o;

    int n_chk = 0;
    int n_err = 0;

    multicycle_control_unit #(.MEM_WAIT_MAX(MEM_WAIT)) dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
        .c_flag(c_flag), .z_flag(z_flag), .alu_z(alu_z),
        .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .flag_c_we(flag_c_we), .flag_z_we(flag_z_we),
        .pc_src(pc_src), .alu_opcode(alu_opcode), .alu_cz(alu_cz),
        .alu_b_sel(alu_b_sel), .rf_wd_sel(rf_wd_sel), .mem_err(mem_err),
        .state_o(state_o)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=no finish required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH back to FETCH. w = MEM wait cycles
    // (above MEM_WAIT means timeout), pre = extra idle FETCH cycles before
    // the fetch is accepted. Ends on the FETCH cycle after the instruction
    // with mem_ready low, which is itself one waiting cycle.
    task automatic run_instr(input logic [3:0] op, input logic [1:0] cz,
                             input logic cf, input logic zf, input logic az,
                             input int w, input int pre, input string tag);
        int   k, mem_seen, n_pre_err;
        int   n_rf, n_fc, n_fz, n_pc, n_mrd, n_mwr, n_merr;
        int   e_cyc, e_rf, e_fc, e_fz, e_pc, e_mrd, e_mwr, e_merr;
        logic [1:0] e_wd, e_src, wd_seen, src_seen, bsel_exec;
        logic [3:0] aop_exec;
        logic cond, tmo, done;

        case (cz)
            2'b00:   cond = 1'b1;
            2'b01:   cond = zf;
            2'b10:   cond = cf;
            default: cond = (op == 4'b0001);
        endcase
        tmo = (w > MEM_WAIT);
        e_cyc = 3; e_rf = 0; e_fc = 0; e_fz = 0; e_pc = 0; e_mrd = 0; e_mwr = 0;
        e_merr = 0; e_wd = 2'b00; e_src = 2'b00;
        case (op)
            4'h0: begin e_cyc = 4; e_rf = 1; e_fc = 1; e_fz = 1; end
            4'h1: begin e_cyc = 4; e_rf = int'(cond); e_fc = int'(cond); e_fz = int'(cond); end
            4'h2: begin e_cyc = (cz == 2'b11) ? 3 : 4; e_rf = int'(cond); e_fz = int'(cond); end
            4'h3: begin e_rf = 1; e_wd = 2'b11; end
            4'h4: begin
                if (tmo) begin e_cyc = 3 + MEM_WAIT + 1; e_mrd = MEM_WAIT + 1; e_merr = 1; end
                else begin e_cyc = 5 + w; e_mrd = w + 1; e_rf = 1; e_fz = 1; e_wd = 2'b01; end
            end
            4'h5: begin
                if (tmo) begin e_cyc = 3 + MEM_WAIT + 1; e_mwr = MEM_WAIT + 1; e_merr = 1; end
                else begin e_cyc = 4 + w; e_mwr = w + 1; end
            end
            4'h8: begin e_pc = int'(az); e_src = 2'b01; end
            4'h9: begin e_rf = 1; e_wd = 2'b10; e_pc = 1; e_src = 2'b01; end
            4'hA: begin e_rf = 1; e_wd = 2'b10; e_pc = 1; e_src = 2'b10; end
            default: ;
        endcase

        n_pre_err = 0;
        for (int i = 0; i < pre; i++) begin
            cyc();
            mem_ready = 1'b0;
            @(negedge clk);
            n_pre_err += int'(mem_err);
        end
        if (pre > 0) chk({tag, ".pre_mem_err"}, n_pre_err, 0);

        cyc();
        instr = {op, 10'($urandom), cz};
        c_flag = cf; z_flag = zf; alu_z = az; mem_ready = 1'b1;
        @(negedge clk);
        chk({tag, ".fetch_state"}, state_o, ST_FETCH);
        chk({tag, ".fetch_ir_we"}, ir_we, 1);
        chk({tag, ".fetch_pc_we"}, pc_we, 1);

        k = 0; done = 1'b0; mem_seen = 0;
        n_rf = 0; n_fc = 0; n_fz = 0; n_pc = 0; n_mrd = 0; n_mwr = 0; n_merr = 0;
        wd_seen = 2'b00; src_seen = 2'b00; bsel_exec = 2'b00; aop_exec = 4'h0;
        while (!done && k < 40) begin
            cyc();
            k++;
            if (k == 3) begin c_flag = ~cf; z_flag = ~zf; alu_z = ~az; end
            if (state_o == ST_MEM) begin
                mem_ready = (mem_seen >= w);
                mem_seen++;
            end else begin
                mem_ready = 1'b0;
            end
            @(negedge clk);
            done = (state_o == ST_FETCH);
            n_rf += int'(rf_we); n_fc += int'(flag_c_we); n_fz += int'(flag_z_we);
            n_pc += int'(pc_we); n_mwr += int'(mem_wr); n_merr += int'(mem_err);
            if (!done) n_mrd += int'(mem_rd);
            if (rf_we) wd_seen = rf_wd_sel;
            if (pc_we) src_seen = pc_src;
            if (k == 2) begin bsel_exec = alu_b_sel; aop_exec = alu_opcode; end
        end

        chk({tag, ".cycles"}, done ? k : -1, e_cyc);
        chk({tag, ".rf_we"}, n_rf, e_rf);
        chk({tag, ".flag_c_we"}, n_fc, e_fc);
        chk({tag, ".flag_z_we"}, n_fz, e_fz);
        chk({tag, ".pc_we_exec"}, n_pc, e_pc);
        chk({tag, ".mem_rd_cycles"}, n_mrd, e_mrd);
        chk({tag, ".mem_wr_cycles"}, n_mwr, e_mwr);
        chk({tag, ".mem_err"}, n_merr, e_merr);
        chk({tag, ".alu_opcode"}, aop_exec, op);
        if (e_rf > 0) chk({tag, ".rf_wd_sel"}, wd_seen, e_wd);
        if (e_pc > 0) chk({tag, ".pc_src"}, src_seen, e_src);
        if (op == 4'h0 || op == 4'h4 || op == 4'h5) chk({tag, ".alu_b_sel"}, bsel_exec, 2'b01);
    endtask

    initial begin
        int n_pulse, pulse_at;
        logic [3:0] rop;
        rst = 1'b0; instr = 16'h0000; mem_ready = 1'b0;
        c_flag = 1'b0; z_flag = 1'b0; alu_z = 1'b0;

        // Reset state
        #2;
        chk("rst.state", state_o, ST_FETCH);
        chk("rst.mem_rd", mem_rd, 0);
        chk("rst.strobes", {ir_we, pc_we, rf_we, mem_wr, flag_c_we, flag_z_we}, 0);
        chk("rst.mem_err", mem_err, 0);
        cyc(); cyc();
        rst = 1'b1;
        #1;
        chk("rel.mem_rd_before_clk", mem_rd, 0);
        cyc();
        chk("rel.mem_rd_first_clk", mem_rd, 1);

        // ADI walked cycle by cycle
        cyc();
        instr = 16'h0000; mem_ready = 1'b1;
        @(negedge clk);
        chk("adi.f_state", state_o, ST_FETCH);
        chk("adi.f_ir_pc", {ir_we, pc_we, mem_rd, pc_src}, 5'b11100);
        cyc(); mem_ready = 1'b0; @(negedge clk);
        chk("adi.d_state", state_o, ST_DECODE);
        chk("adi.d_wr", {rf_we, flag_c_we, flag_z_we}, 0);
        cyc(); @(negedge clk);
        chk("adi.e_state", state_o, ST_EXEC);
        chk("adi.e_bsel", alu_b_sel, 2'b01);
        chk("adi.e_wr", {rf_we, flag_c_we, flag_z_we}, 0);
        cyc(); @(negedge clk);
        chk("adi.w_state", state_o, ST_WB);
        chk("adi.w_wr", {rf_we, flag_c_we, flag_z_we}, 3'b111);
        cyc(); @(negedge clk);
        chk("adi.back_fetch", state_o, ST_FETCH);
        chk("adi.back_wr", {rf_we, flag_c_we, flag_z_we}, 0);

        // Directed instruction scenarios
        run_instr(4'h1, 2'b01, 1'b1, 1'b0, 1'b0, 0, 0, "adz_z0");
        run_instr(4'h1, 2'b01, 1'b0, 1'b1, 1'b0, 0, 0, "adz_z1");
        run_instr(4'h1, 2'b10, 1'b0, 1'b1, 1'b0, 0, 0, "adc_c0");
        run_instr(4'h4, 2'b00, 1'b0, 1'b0, 1'b0, 3, 0, "lw_w3");
        run_instr(4'h8, 2'b00, 1'b0, 1'b0, 1'b1, 0, 0, "beq_z1");
        run_instr(4'h8, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0, "beq_z0");
        run_instr(4'h9, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0, "jal");
        run_instr(4'hA, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0, "jlr");
        run_instr(4'h3, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0, "lhi");
        run_instr(4'h2, 2'b11, 1'b1, 1'b1, 1'b0, 0, 0, "ndu_cz11");
        run_instr(4'h7, 2'b00, 1'b1, 1'b1, 1'b1, 0, 0, "nop7");
        run_instr(4'h5, 2'b00, 1'b0, 1'b0, 1'b0, 2, 0, "sw_w2");
        // 15 waiting FETCH cycles (closing cycle + 14) must not time out
        run_instr(4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 0, 14, "fetch_wait15");
        run_instr(4'h5, 2'b00, 1'b0, 1'b0, 1'b0, MEM_WAIT, 0, "sw_w15");
        run_instr(4'h5, 2'b00, 1'b0, 1'b0, 1'b0, MEM_WAIT + 1, 0, "sw_timeout");
        run_instr(4'h4, 2'b00, 1'b0, 1'b0, 1'b0, MEM_WAIT + 1, 0, "lw_timeout");

        // FETCH timeout: the closing FETCH cycle above is wait 1, so the
        // 16th waiting cycle ends with loop iteration 15.
        n_pulse = 0; pulse_at = -1;
        mem_ready = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            cyc();
            @(negedge clk);
            if (mem_err) begin n_pulse++; pulse_at = i; end
            chk("fto.state", state_o, ST_FETCH);
            chk("fto.ir_we", ir_we, 0);
        end
        chk("fto.pulses", n_pulse, 1);
        chk("fto.pulse_cycle", pulse_at, 16);
        run_instr(4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0, "after_fto");

        // Reset during SW MEM
        cyc();
        instr = {4'b0101, 12'h000}; mem_ready = 1'b1;
        @(negedge clk);
        cyc(); mem_ready = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        chk("swrst.in_mem", state_o, ST_MEM);
        chk("swrst.mem_wr_before", mem_wr, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("swrst.mem_wr_drop", mem_wr, 0);
        chk("swrst.state", state_o, ST_FETCH);
        chk("swrst.rf_we", rf_we, 0);
        cyc();
        mem_ready = 1'b1;
        @(negedge clk);
        chk("swrst.hold_wr", {rf_we, mem_wr, mem_rd, pc_we, ir_we}, 0);
        cyc();
        rst = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        chk("swrst.rel_mem_rd", mem_rd, 0);
        cyc();
        @(negedge clk);
        chk("swrst.first_fetch", {mem_rd, state_o}, {1'b1, ST_FETCH});

        // Random instructions
        for (int n = 0; n < 60; n++) begin
            int w;
            rop = 4'($urandom_range(0, 15));
            w = ($urandom_range(0, 9) == 0) ? MEM_WAIT + 1 : int'($urandom_range(0, 4));
            run_instr(rop, 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      w, 0, $sformatf("rnd%0d_op%0h", n, rop));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
